// File: rtl/csel_adder_pipe.sv
// csel_adder_pipe: two-stage pipelined carry-select adder/subtractor.
// Stage 1 registers, for every BLOCK-bit slice, the slice result under both
// possible carry-ins. Stage 2 resolves the slice carry chain, picks the right
// conditional results and registers sum, carry-out and signed overflow.
// Both stages use a valid/ready handshake that lets a stalled output stage
// still accept one more operation into an empty stage 1.
module csel_adder_pipe #(
  parameter int WIDTH = 16,  // operand width, integer multiple of BLOCK
  parameter int BLOCK = 4    // carry-select slice width, 1..WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NBLK = WIDTH / BLOCK;

  typedef logic [NBLK-1:0][BLOCK-1:0] slice_vec_t;

  // Handshake
  logic adv1;
  logic adv2;
  logic v1_q;
  logic v2_q;

  // Stage-1 state and its next-state values
  logic [WIDTH-1:0] bx;
  slice_vec_t       s0_q, s0_d;
  slice_vec_t       s1_q, s1_d;
  logic [NBLK-1:0]  co0_q, co0_d;
  logic [NBLK-1:0]  co1_q, co1_d;
  logic             cm0_q, cm0_d;
  logic             cm1_q, cm1_d;
  logic             c0_q, c0_d;

  // Stage-2 state and its next-state values
  logic [NBLK:0]    csel;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Stage 2 moves when it is empty or its result is being taken; stage 1
  // moves when it is empty or stage 2 moves. in_ready is combinational so a
  // full pipeline can shift on the same edge out_ready returns.
  assign adv2     = !v2_q || out_ready;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;

  // Stage 1: per-slice conditional sums for carry-in 0 and carry-in 1.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    bx    = sub ? ~b : b;
    c0_d  = sub ? ~cin : cin;
    s0_d  = '0;
    s1_d  = '0;
    co0_d = '0;
    co1_d = '0;
    for (int k = 0; k < NBLK; k++) begin
      {co0_d[k], s0_d[k]} = {1'b0, a[k*BLOCK +: BLOCK]}
                          + {1'b0, bx[k*BLOCK +: BLOCK]};
      {co1_d[k], s1_d[k]} = {1'b0, a[k*BLOCK +: BLOCK]}
                          + {1'b0, bx[k*BLOCK +: BLOCK]}
                          + {{BLOCK{1'b0}}, 1'b1};
    end
    // Carry into the MSB recovered from the MSB sum bit: s = a ^ bx ^ c.
    // This also covers BLOCK = 1, where it equals the assumed carry-in.
    cm0_d = s0_d[NBLK-1][BLOCK-1] ^ a[WIDTH-1] ^ bx[WIDTH-1];
    cm1_d = s1_d[NBLK-1][BLOCK-1] ^ a[WIDTH-1] ^ bx[WIDTH-1];
  end

  // Stage 2: resolve the slice carry chain and select the final result.
  always_comb begin
    csel    = '0;
    sum_d   = '0;
    csel[0] = c0_q;
    for (int k = 0; k < NBLK; k++) begin
      csel[k+1]                = csel[k] ? co1_q[k] : co0_q[k];
      sum_d[k*BLOCK +: BLOCK]  = csel[k] ? s1_q[k] : s0_q[k];
    end
    cout_d = csel[NBLK];
    ovf_d  = cout_d ^ (csel[NBLK-1] ? cm1_q : cm0_q);
  end

  // Valid flags for both stages.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      if (adv2) v2_q <= v1_q;
      if (adv1) v1_q <= in_valid;
    end
  end

  // Stage-1 data registers load only when an operation is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the data registers are cleared on reset as well, so nothing left
    // from before a reset can be observed afterwards.
    if (!rst_n) begin
      s0_q  <= '0;
      s1_q  <= '0;
      co0_q <= '0;
      co1_q <= '0;
      cm0_q <= 1'b0;
      cm1_q <= 1'b0;
      c0_q  <= 1'b0;
    end else if (adv1 && in_valid) begin
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      co0_q <= co0_d;
      co1_q <= co1_d;
      cm0_q <= cm0_d;
      cm1_q <= cm1_d;
      c0_q  <= c0_d;
    end
  end

  // Stage-2 result registers load only when a valid stage-1 entry moves in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (adv2 && v1_q) begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid = v2_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Testbench for csel_adder_pipe. Five configurations (16/4, 16/1, 16/16,
// 32/8, 8/2) share one handshake and operand stream; a scoreboard queue holds
// expected results per accepted operation and is compared when outputs appear.
module tb_csel_adder_pipe;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic out_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic cin_in;
  logic sub_in;

  logic ir [5];
  logic ov [5];
  logic co [5];
  logic of [5];
  logic [15:0] s16_4, s16_1, s16_16;
  logic [31:0] s32_8;
  logic [7:0]  s8_2;

  always #5 clk = ~clk;

  csel_adder_pipe #(.WIDTH(16), .BLOCK(4)) u_16_4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a_in[15:0]), .b(b_in[15:0]), .cin(cin_in), .sub(sub_in),
    .out_valid(ov[0]), .out_ready(out_ready), .sum(s16_4), .cout(co[0]), .ovf(of[0]));

  csel_adder_pipe #(.WIDTH(16), .BLOCK(1)) u_16_1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .a(a_in[15:0]), .b(b_in[15:0]), .cin(cin_in), .sub(sub_in),
    .out_valid(ov[1]), .out_ready(out_ready), .sum(s16_1), .cout(co[1]), .ovf(of[1]));

  csel_adder_pipe #(.WIDTH(16), .BLOCK(16)) u_16_16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .a(a_in[15:0]), .b(b_in[15:0]), .cin(cin_in), .sub(sub_in),
    .out_valid(ov[2]), .out_ready(out_ready), .sum(s16_16), .cout(co[2]), .ovf(of[2]));

  csel_adder_pipe #(.WIDTH(32), .BLOCK(8)) u_32_8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
    .a(a_in), .b(b_in), .cin(cin_in), .sub(sub_in),
    .out_valid(ov[3]), .out_ready(out_ready), .sum(s32_8), .cout(co[3]), .ovf(of[3]));

  csel_adder_pipe #(.WIDTH(8), .BLOCK(2)) u_8_2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[4]),
    .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in), .sub(sub_in),
    .out_valid(ov[4]), .out_ready(out_ready), .sum(s8_2), .cout(co[4]), .ovf(of[4]));

  typedef struct {
    logic [15:0] s16; logic c16; logic o16;
    logic [31:0] s32; logic c32; logic o32;
    logic [7:0]  s8;  logic c8;  logic o8;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  logic v1m = 1'b0;
  logic v2m = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural a +/- b +/- cin at width w: returns {ovf, cout, sum}.
  function automatic logic [33:0] model(input logic [31:0] av, input logic [31:0] bv,
                                        input logic ci, input logic sb, input int w);
    longint mask, ua, ub, sa, sb_s, r, rs, hi, lo;
    logic [31:0] s;
    logic c, o;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(av) & mask;
    ub   = longint'(bv) & mask;
    r    = sb ? ua - ub - longint'(ci) : ua + ub + longint'(ci);
    s    = 32'(r & mask);
    c    = sb ? (r >= 0) : ((r >> w) & 1) != 0;
    hi   = (longint'(1) << (w - 1)) - 1;
    lo   = -(longint'(1) << (w - 1));
    sa   = (ua > hi) ? ua - (longint'(1) << w) : ua;
    sb_s = (ub > hi) ? ub - (longint'(1) << w) : ub;
    rs   = sb ? sa - sb_s - longint'(ci) : sa + sb_s + longint'(ci);
    o    = (rs > hi) || (rs < lo);
    return {o, c, s};
  endfunction

  task automatic cmp_out(input exp_t e);
    check("sum16_4",  s16_4,  e.s16); check("cout16_4",  co[0], e.c16); check("ovf16_4",  of[0], e.o16);
    check("sum16_1",  s16_1,  e.s16); check("cout16_1",  co[1], e.c16); check("ovf16_1",  of[1], e.o16);
    check("sum16_16", s16_16, e.s16); check("cout16_16", co[2], e.c16); check("ovf16_16", of[2], e.o16);
    check("sum32_8",  s32_8,  e.s32); check("cout32_8",  co[3], e.c32); check("ovf32_8",  of[3], e.o32);
    check("sum8_2",   s8_2,   e.s8);  check("cout8_2",   co[4], e.c8);  check("ovf8_2",   of[4], e.o8);
  endtask

  // One cycle: drive inputs, check handshake and outputs, record acceptance,
  // advance the occupancy model, move to the next falling edge.
  // use_k replaces the 16-bit expectation with a hand-written {ovf,cout,sum}.
  task automatic step(input logic iv, input logic ordy, input logic [31:0] av,
                      input logic [31:0] bv, input logic ci, input logic sb,
                      input logic use_k, input logic [17:0] kval, output logic acc);
    exp_t e;
    logic [33:0] m;
    logic exp_ir, adv1m, adv2m;
    in_valid  = iv;
    out_ready = ordy;
    a_in      = av;
    b_in      = bv;
    cin_in    = ci;
    sub_in    = sb;
    #1;
    exp_ir = !v1m || !v2m || ordy;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("in_ready%0d", i), ir[i], exp_ir);
      check($sformatf("out_valid%0d", i), ov[i], v2m);
    end
    if (ov[0]) begin
      check("sb_nonempty", q.size() > 0, 1'b1);
      if (q.size() > 0) begin
        cmp_out(q[0]);
        if (ordy) void'(q.pop_front());
      end
    end
    acc = iv && ir[0];
    if (acc) begin
      m = model(av, bv, ci, sb, 16); {e.o16, e.c16, e.s16} = {m[33], m[32], m[15:0]};
      if (use_k) {e.o16, e.c16, e.s16} = kval;
      m = model(av, bv, ci, sb, 32); {e.o32, e.c32, e.s32} = m;
      m = model(av, bv, ci, sb, 8);  {e.o8, e.c8, e.s8} = {m[33], m[32], m[7:0]};
      q.push_back(e);
    end
    adv2m = !v2m || ordy;
    adv1m = !v1m || adv2m;
    if (adv2m) v2m = v1m;
    if (adv1m) v1m = iv;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, '0, acc);
  endtask

  typedef struct { logic [15:0] a; logic [15:0] b; logic ci; logic sb; logic [17:0] k; } vec_t;

  initial begin
    vec_t vecs [6];
    logic acc;
    int   idx;
    logic [31:0] ra [4];
    logic [31:0] rb [4];

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000}};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000}};
    vecs[2] = '{16'h1234, 16'h0F0F, 1'b1, 1'b0, {1'b0, 1'b0, 16'h2144}};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE}};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF}};
    vecs[5] = '{16'h0010, 16'h0003, 1'b1, 1'b1, {1'b0, 1'b1, 16'h000C}};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rst_out_valid%0d", i), ov[i], 1'b0);
      check($sformatf("rst_in_ready%0d", i), ir[i], 1'b1);
      check($sformatf("rst_cout%0d", i), co[i], 1'b0);
      check($sformatf("rst_ovf%0d", i), of[i], 1'b0);
    end
    check("rst_sum16_4", s16_4, 16'h0);
    check("rst_sum32_8", s32_8, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors back to back, full throughput.
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b1, {16'h0, vecs[i].a}, {16'h0, vecs[i].b}, vecs[i].ci, vecs[i].sb,
           1'b1, vecs[i].k, acc);
    idle(3);

    // Backpressure: four ops offered with out_ready low.
    for (int i = 0; i < 4; i++) begin ra[i] = $urandom; rb[i] = $urandom; end
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 1'b0, ra[idx], rb[idx], idx[0], idx[1], 1'b0, '0, acc);
      if (acc) idx++;
    end
    check("bp_accepted", idx, 2);
    for (int c = 0; c < 10 && idx < 4; c++) begin
      step(1'b1, 1'b1, ra[idx], rb[idx], idx[0], idx[1], 1'b0, '0, acc);
      if (acc) idx++;
    end
    check("bp_all_accepted", idx, 4);
    idle(4);
    check("bp_drained", q.size(), 0);

    // Reset with both stages full.
    idx = 0;
    for (int c = 0; c < 6 && idx < 2; c++) begin
      step(1'b1, 1'b0, $urandom, $urandom, 1'b0, 1'b0, 1'b0, '0, acc);
      if (acc) idx++;
    end
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, acc);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("mrst_out_valid%0d", i), ov[i], 1'b0);
      check($sformatf("mrst_cout%0d", i), co[i], 1'b0);
      check($sformatf("mrst_ovf%0d", i), of[i], 1'b0);
    end
    check("mrst_sum16_4", s16_4, 16'h0);
    check("mrst_sum32_8", s32_8, 32'h0);
    check("mrst_sum8_2", s8_2, 8'h0);
    q.delete();
    v1m = 1'b0;
    v2m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 32'h0000_1234, 32'h0000_0F0F, 1'b1, 1'b0, 1'b1,
         {1'b0, 1'b0, 16'h2144}, acc);
    idle(4);
    check("mrst_drained", q.size(), 0);

    // Random traffic with random valid/ready on all configurations.
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom, $urandom,
           1'($urandom), 1'($urandom), 1'b0, '0, acc);
    idle(5);
    check("final_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
